// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage pipeline: word loads/stores to a local data memory
// with a fixed multi-cycle latency, stalling upstream and bubbling WB while busy.
module memory_access_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  control_mem_in,
  input  logic [1:0]  control_wb_in,
  input  logic [31:0] Alu_result_in,
  input  logic [31:0] Write_data_in,
  input  logic [4:0]  Write_reg_in,
  output logic [1:0]  control_wb_out,
  output logic [31:0] Read_data_out,
  output logic [31:0] Alu_result_out,
  output logic [4:0]  Write_reg_out,
  output logic        stall,
  output logic        align_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              access;
  logic              mem_we;

  // Upper address bits are dropped, so byte addresses wrap modulo DEPTH*4.
  assign idx       = Alu_result_in[ADDR_W+1:2];
  assign access    = |control_mem_in;
  assign align_err = err_q;

  // NOTE: every output and next-state variable gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    mem_we         = 1'b0;
    stall          = 1'b0;
    control_wb_out = control_wb_in;
    Read_data_out  = '0;
    Alu_result_out = Alu_result_in;
    Write_reg_out  = Write_reg_in;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall          = 1'b1;
          control_wb_out = 2'b00;
          state_d        = BUSY;
          cnt_d          = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall          = 1'b1;
          control_wb_out = 2'b00;
          cnt_d          = cnt_q - 4'd1;
        end else begin
          // Completion cycle: a read-and-write request is treated as a store.
          state_d = IDLE;
          if (control_mem_in == 2'b10) Read_data_out = mem[idx];
          if (control_mem_in[0])       mem_we        = 1'b1;
          if ((access && (Alu_result_in[1:0] != 2'b00)) || (control_mem_in == 2'b11))
            err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset dominates: no stall requested and no store committed while it is held.
    if (reset) begin
      stall  = 1'b0;
      mem_we = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the memory array has no reset; its contents survive reset and an
  // aborted store is blocked by mem_we rather than by clearing the array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= Write_data_in;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: three instances at LATENCY 2, 3 and 1,
// each with its own stimulus and reset so scenarios do not interfere.
module tb_memory_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance map: 0 -> LATENCY 2, 1 -> LATENCY 3, 2 -> LATENCY 1.
  logic [2:0]        rst;
  logic [2:0][1:0]   cmi, wbi, wbo;
  logic [2:0][31:0]  alu, wdi, rdo, aluo;
  logic [2:0][4:0]   wri, wro;
  logic [2:0]        stall_o, err_o;

  int errors = 0;
  int checks = 0;

  memory_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst[0]), .control_mem_in(cmi[0]), .control_wb_in(wbi[0]),
    .Alu_result_in(alu[0]), .Write_data_in(wdi[0]), .Write_reg_in(wri[0]),
    .control_wb_out(wbo[0]), .Read_data_out(rdo[0]), .Alu_result_out(aluo[0]),
    .Write_reg_out(wro[0]), .stall(stall_o[0]), .align_err(err_o[0]));

  memory_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst[1]), .control_mem_in(cmi[1]), .control_wb_in(wbi[1]),
    .Alu_result_in(alu[1]), .Write_data_in(wdi[1]), .Write_reg_in(wri[1]),
    .control_wb_out(wbo[1]), .Read_data_out(rdo[1]), .Alu_result_out(aluo[1]),
    .Write_reg_out(wro[1]), .stall(stall_o[1]), .align_err(err_o[1]));

  memory_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[2]), .control_mem_in(cmi[2]), .control_wb_in(wbi[2]),
    .Alu_result_in(alu[2]), .Write_data_in(wdi[2]), .Write_reg_in(wri[2]),
    .control_wb_out(wbo[2]), .Read_data_out(rdo[2]), .Alu_result_out(aluo[2]),
    .Write_reg_out(wro[2]), .stall(stall_o[2]), .align_err(err_o[2]));

  // One full access on instance k; stall is expected high for the first lat
  // cycles and the completion cycle carries the pass-through values and exp_rd.
  task automatic do_access(input int k, input int lat, input logic [1:0] m,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input string nm);
    logic exp_st;
    cmi[k] = m; wbi[k] = 2'b01; alu[k] = a; wdi[k] = wd; wri[k] = 5'd9;
    for (int c = 0; c <= lat; c++) begin
      #1;
      exp_st = (c < lat);
      checks++;
      if (stall_o[k] !== exp_st) begin
        errors++;
        $display("FAIL %s stall cyc%0d: got %0b want %0b", nm, c, stall_o[k], exp_st);
      end
      checks++;
      if (wbo[k] !== (exp_st ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL %s wb_out cyc%0d: got %b want %b", nm, c, wbo[k], exp_st ? 2'b00 : 2'b01);
      end
      if (!exp_st) begin
        checks++;
        if (rdo[k] !== exp_rd) begin
          errors++;
          $display("FAIL %s read_data: got %h want %h", nm, rdo[k], exp_rd);
        end
        checks++;
        if (aluo[k] !== a || wro[k] !== 5'd9) begin
          errors++;
          $display("FAIL %s passthru: got %h/%0d want %h/9", nm, aluo[k], wro[k], a);
        end
      end
      @(posedge clk); #1;
    end
    cmi[k] = 2'b00;
  endtask

  task automatic test_reset;
    rst = 3'b111;
    cmi = '0; wbi = '0; alu = '0; wdi = '0; wri = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_o !== 3'b000 || err_o !== 3'b000) begin
      errors++;
      $display("FAIL reset state: got stall=%b err=%b want 000/000", stall_o, err_o);
    end
    rst = 3'b000;
    cmi[0] = 2'b00; wbi[0] = 2'b10; alu[0] = 32'h0000_0042; wri[0] = 5'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stall_o[0] !== 1'b0 || wbo[0] !== 2'b10 || aluo[0] !== 32'h0000_0042 ||
          wro[0] !== 5'd5 || rdo[0] !== 32'h0 || err_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL alu_op cyc%0d: got st=%b wb=%b alu=%h wr=%0d rd=%h err=%b want 0/10/00000042/5/0/0",
                 c, stall_o[0], wbo[0], aluo[0], wro[0], rdo[0], err_o[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_load;
    do_access(0, 2, 2'b01, 32'h10, 32'hDEAD_BEEF, 32'h0, "store_10");
    do_access(0, 2, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, "load_10");
  endtask

  task automatic test_wrap;
    do_access(0, 2, 2'b01, 32'h400, 32'h1234_5678, 32'h0, "store_400");
    do_access(0, 2, 2'b10, 32'h000, 32'h0, 32'h1234_5678, "load_000");
  endtask

  task automatic test_misaligned;
    checks++;
    if (err_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_before_misalign: got %b want 0", err_o[0]);
    end
    do_access(0, 2, 2'b10, 32'h13, 32'h0, 32'hDEAD_BEEF, "load_13");
    checks++;
    if (err_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_after_misalign: got %b want 1", err_o[0]);
    end
    do_access(0, 2, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, "clean_load");
    checks++;
    if (err_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err_o[0]);
    end
  endtask

  task automatic test_read_write_both;
    checks++;
    if (err_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL err_before_rw: got %b want 0", err_o[2]);
    end
    do_access(2, 1, 2'b11, 32'h20, 32'hA5A5_A5A5, 32'h0, "rw_20");
    checks++;
    if (err_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL err_after_rw: got %b want 1", err_o[2]);
    end
    do_access(2, 1, 2'b10, 32'h20, 32'h0, 32'hA5A5_A5A5, "load_20");
  endtask

  task automatic test_reset_mid_access;
    do_access(1, 3, 2'b01, 32'h8, 32'h0BAD_F00D, 32'h0, "prior_store_8");
    cmi[1] = 2'b01; wbi[1] = 2'b01; alu[1] = 32'h8; wdi[1] = 32'hFFFF_FFFF; wri[1] = 5'd9;
    #1;
    checks++;
    if (stall_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort stall_cyc0: got %b want 1", stall_o[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort stall_cyc1: got %b want 1", stall_o[1]);
    end
    rst[1] = 1'b1;
    #1;
    checks++;
    if (stall_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort stall_drop: got %b want 0", stall_o[1]);
    end
    @(posedge clk); #1;
    cmi[1] = 2'b00;
    rst[1] = 1'b0;
    #1;
    checks++;
    if (stall_o[1] !== 1'b0 || wbo[1] !== 2'b01) begin
      errors++;
      $display("FAIL abort idle: got stall=%b wb=%b want 0/01", stall_o[1], wbo[1]);
    end
    @(posedge clk); #1;
    do_access(1, 3, 2'b10, 32'h8, 32'h0, 32'h0BAD_F00D, "load_8_after_abort");
  endtask

  task automatic test_back_to_back;
    do_access(2, 1, 2'b01, 32'h24, 32'h600D_CAFE, 32'h0, "store_24");
    do_access(2, 1, 2'b10, 32'h20, 32'h0, 32'hA5A5_A5A5, "b2b_load_20");
    do_access(2, 1, 2'b10, 32'h24, 32'h0, 32'h600D_CAFE, "b2b_load_24");
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_store_load;
    test_wrap;
    test_misaligned;
    test_read_write_both;
    test_reset_mid_access;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM stage of the 5-stage pipelined CPU; sits between the EX/MEM pipe register and the MEM/WB pipe register.
- Performs word loads and stores to an internal data memory with a parameterised multi-cycle access latency.
- Raises stall to freeze upstream stages while an access is in flight.
- Presents the WB control bits, load data, ALU result and destination register to the MEM/WB register, inserting a bubble while stalled.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory; power of two.
- ADDR_W, 8, log2(DEPTH); width of the word index.
- LATENCY, 2, number of stall cycles per memory access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- control_mem_in  input  2  bit1 = MemRead, bit0 = MemWrite
- control_wb_in  input  2  WB control bits, passed through
- Alu_result_in  input  32  byte address for loads/stores; pass-through result otherwise
- Write_data_in  input  32  store data
- Write_reg_in  input  5  destination register, passed through
- control_wb_out  output  2  to MEM/WB register
- Read_data_out  output  32  load data to MEM/WB register
- Alu_result_out  output  32  to MEM/WB register
- Write_reg_out  output  5  to MEM/WB register
- stall  output  1  high = upstream must hold EX/MEM contents
- align_err  output  1  sticky misaligned/illegal-access flag

Behaviour:
- Clocking: one clock (clk); reset asynchronous, active-high.
- Internal state:
  - FSM: IDLE, BUSY.
  - Down-counter cnt, 4 bits.
  - Sticky err register.
  - Memory array mem[DEPTH].
- Reset: FSM = IDLE, cnt = 0, align_err = 0. Memory contents are not cleared.
- Reset asserted mid-access aborts the access; a pending store is not written.
- Address and data rules:
  - access = control_mem_in[1] | control_mem_in[0].
  - Word index = Alu_result_in[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- IDLE state:
  - access = 0: stall = 0. Outputs pass through combinationally: control_wb_out = control_wb_in, Alu_result_out = Alu_result_in, Write_reg_out = Write_reg_in, Read_data_out = 0. No state change.
  - access = 1: stall = 1, control_wb_out = 0 (bubble), Read_data_out = 0. Next state BUSY with cnt <= LATENCY-1.
- BUSY state, cnt != 0: stall = 1, control_wb_out = 0; cnt decrements each cycle.
- BUSY state, cnt == 0 (completion cycle):
  - stall = 0; outputs pass through as in IDLE.
  - Read: Read_data_out = mem[index] (combinational read).
  - Write: at the posedge, mem[index] <= Write_data_in; Read_data_out = 0.
  - Next state is IDLE.
- Access timing:
  - Each access occupies LATENCY+1 cycles, with stall high for the first LATENCY cycles.
  - Back-to-back accesses therefore re-stall, because the next access is seen in IDLE.
- Input stability: upstream holds all inputs stable while stall = 1. The block samples the address at completion only and does not latch it.
- Error conditions (err set at the completion-cycle posedge, held until reset):
  - Misaligned: Alu_result_in[1:0] != 0 with access = 1. The access still completes on the truncated word index.
  - Both MemRead and MemWrite set: the store is performed, Read_data_out = 0.
- Simultaneous events: reset dominates all; the store commits only on the completion-cycle edge.
- Outputs are combinational from the current state and inputs. There is no extra register latency; the MEM/WB register provides it.

Test Plan:
- Reset then ALU op: reset 3 cycles; control_mem_in = 0, control_wb_in = 2'b10, Alu_result_in = 32'h0000_0042, Write_reg_in = 5 -> stall = 0 every cycle; outputs equal inputs; Read_data_out = 0; align_err = 0.
- Store then load, LATENCY = 2: store 32'hDEAD_BEEF to address 0x10 -> stall high 2 cycles, low on the 3rd; load from 0x10 -> stall high 2 cycles, then Read_data_out = 32'hDEAD_BEEF with control_wb_out = control_wb_in; during stall control_wb_out = 0.
- Wrap-around, DEPTH = 256: store 32'h1234_5678 to 0x400; load from 0x000 -> Read_data_out = 32'h1234_5678.
- Misaligned and illegal access: load at 0x13 -> data of word 4, align_err = 1 after completion and stays 1 through later clean accesses. control_mem_in = 2'b11 on address 0x20 with data 32'hA5A5_A5A5 -> the store occurs and Read_data_out = 0 on completion.
- Reset mid-access, LATENCY = 3: start a store of 32'hFFFF_FFFF to 0x8; assert reset in the 2nd stall cycle -> stall drops immediately (async) and the FSM is in IDLE; a subsequent load of 0x8 returns the prior value, not 32'hFFFF_FFFF.
- Back-to-back loads, LATENCY = 1: two consecutive loads -> pattern stall = 1, 0, 1, 0; each completion cycle carries the correct data.
